// File: rtl/pc_update_unit.sv
// Program counter update with branch/jump select and misaligned-target trap.
// Two-state RUN/TRAP machine; taken conditional branches are counted.
module pc_update_unit #(
  parameter int                    word_size  = 32,
  parameter logic [word_size-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [word_size-1:0] EXC_VECTOR = 32'h0000_0180
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 PCWrite,
  input  logic                 PCWriteCond,
  input  logic                 Branch,
  input  logic [1:0]           PCSource,
  input  logic [word_size-1:0] alu_result,
  input  logic [word_size-1:0] alu_out,
  input  logic [25:0]          jump_field,
  output logic [word_size-1:0] pc,
  output logic [word_size-1:0] epc,
  output logic [word_size-1:0] bad_addr,
  output logic                 trap,
  output logic [15:0]          branch_cnt
);

  typedef enum logic {
    RUN,
    TRAP
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [word_size-1:0] jump_target;
  logic [word_size-1:0] next_pc;
  logic                 pc_en;
  logic                 misaligned;
  logic                 cond_taken;
  logic [word_size-1:0] pc_d;
  logic [word_size-1:0] epc_d;
  logic [word_size-1:0] bad_d;
  logic [15:0]          cnt_d;

  assign jump_target = {pc[word_size-1:28], jump_field, 2'b00};
  assign pc_en       = PCWrite | (PCWriteCond & Branch);
  assign cond_taken  = PCWriteCond & Branch & ~PCWrite;
  assign misaligned  = |next_pc[1:0];
  assign trap        = (state_q == TRAP);

  // Next-PC source select.
  always_comb begin
    next_pc = alu_result;
    unique case (PCSource)
      2'b00: next_pc = alu_result;
      2'b01: next_pc = alu_out;
      2'b10: next_pc = jump_target;
      2'b11: next_pc = epc;
    endcase
  end

  // Next-state and register updates for the RUN/TRAP machine.
  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    epc_d   = epc;
    bad_d   = bad_addr;
    cnt_d   = branch_cnt;
    unique case (state_q)
      RUN: begin
        if (pc_en) begin
          if (misaligned) begin
            epc_d   = pc;
            bad_d   = next_pc;
            state_d = TRAP;
          end else begin
            pc_d = next_pc;
            if (cond_taken)
              cnt_d = branch_cnt + 16'd1;
          end
        end
      end
      TRAP: begin
        pc_d    = EXC_VECTOR;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // State and architectural registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc         <= RESET_PC;
      epc        <= '0;
      bad_addr   <= '0;
      branch_cnt <= '0;
    end else begin
      state_q    <= state_d;
      pc         <= pc_d;
      epc        <= epc_d;
      bad_addr   <= bad_d;
      branch_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_update_unit.sv
// Scoreboard bench for pc_update_unit.
// Stimulus pushes expected state; a negedge monitor pops and compares.
module tb_pc_update_unit;

  logic        clk;
  logic        rst_n;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        Branch;
  logic [1:0]  PCSource;
  logic [31:0] alu_result;
  logic [31:0] alu_out;
  logic [25:0] jump_field;
  logic [31:0] pc;
  logic [31:0] epc;
  logic [31:0] bad_addr;
  logic        trap;
  logic [15:0] branch_cnt;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] bad;
    logic        trap;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  pc_update_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PCWrite    (PCWrite),
    .PCWriteCond(PCWriteCond),
    .Branch     (Branch),
    .PCSource   (PCSource),
    .alu_result (alu_result),
    .alu_out    (alu_out),
    .jump_field (jump_field),
    .pc         (pc),
    .epc        (epc),
    .bad_addr   (bad_addr),
    .trap       (trap),
    .branch_cnt (branch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (pc !== e.pc || epc !== e.epc || bad_addr !== e.bad ||
          trap !== e.trap || branch_cnt !== e.cnt) begin
        failures++;
        $display("FAIL %s: got pc=%h epc=%h bad=%h trap=%b cnt=%h exp pc=%h epc=%h bad=%h trap=%b cnt=%h",
                 e.name, pc, epc, bad_addr, trap, branch_cnt,
                 e.pc, e.epc, e.bad, e.trap, e.cnt);
      end
    end
  end

  task automatic drive(input logic pw, input logic pwc,
                       input logic br, input logic [1:0] src,
                       input logic [31:0] res, input logic [31:0] out,
                       input logic [25:0] jf);
    PCWrite     = pw;
    PCWriteCond = pwc;
    Branch      = br;
    PCSource    = src;
    alu_result  = res;
    alu_out     = out;
    jump_field  = jf;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string nm, input logic [31:0] p,
                           input logic [31:0] e, input logic [31:0] b,
                           input logic t, input logic [15:0] c);
    exp_t x;
    x.name = nm;
    x.pc   = p;
    x.epc  = e;
    x.bad  = b;
    x.trap = t;
    x.cnt  = c;
    q.push_back(x);
  endtask

  task automatic set_pc(input logic [31:0] v);
    drive(1, 0, 0, 2'b00, v, 0, 0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 0, 0);
    #1;
    expect_st("reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'h0);
    tick();
    rst_n = 1'b1;

    drive(1, 0, 0, 2'b00, 32'h4, 0, 0);
    tick();
    expect_st("first_edge", 32'h4, 0, 0, 0, 16'h0);

    set_pc(32'h100);
    drive(0, 1, 1, 2'b01, 0, 32'h140, 0);
    tick();
    expect_st("br_taken", 32'h140, 0, 0, 0, 16'h1);

    set_pc(32'h100);
    drive(0, 1, 0, 2'b01, 0, 32'h140, 0);
    tick();
    expect_st("br_not_taken", 32'h100, 0, 0, 0, 16'h1);

    drive(0, 0, 0, 2'b00, 32'h300, 32'h304, 0);
    tick();
    expect_st("hold", 32'h100, 0, 0, 0, 16'h1);

    drive(1, 1, 1, 2'b01, 0, 32'h144, 0);
    tick();
    expect_st("pw_dominates", 32'h144, 0, 0, 0, 16'h1);

    set_pc(32'h0040_0010);
    drive(1, 0, 0, 2'b10, 0, 0, 26'h0000_123);
    tick();
    expect_st("jump", 32'h0000_048C, 0, 0, 0, 16'h1);

    set_pc(32'hA000_0000);
    drive(1, 0, 0, 2'b10, 0, 0, 26'h3FF_FFFF);
    tick();
    expect_st("jump_hi", 32'hAFFF_FFFC, 0, 0, 0, 16'h1);

    set_pc(32'h200);
    drive(0, 1, 1, 2'b01, 0, 32'h202, 0);
    tick();
    expect_st("mis_br_e1", 32'h200, 32'h200, 32'h202, 1, 16'h1);
    drive(1, 0, 0, 2'b00, 32'h500, 0, 0);
    tick();
    expect_st("mis_br_e2", 32'h180, 32'h200, 32'h202, 0, 16'h1);

    drive(1, 0, 0, 2'b11, 0, 0, 0);
    tick();
    expect_st("eret", 32'h200, 32'h200, 32'h202, 0, 16'h1);

    drive(1, 0, 0, 2'b00, 32'h301, 0, 0);
    tick();
    expect_st("mis_pw_e1", 32'h200, 32'h200, 32'h301, 1, 16'h1);
    drive(0, 1, 1, 2'b01, 0, 32'h400, 0);
    tick();
    expect_st("mis_pw_e2", 32'h180, 32'h200, 32'h301, 0, 16'h1);

    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    expect_st("reset2", 32'h0, 0, 0, 0, 16'h0);
    tick();
    rst_n = 1'b1;

    drive(0, 1, 1, 2'b01, 0, 32'h1000, 0);
    for (int i = 0; i < 65535; i++) tick();
    expect_st("cnt_ffff", 32'h1000, 0, 0, 0, 16'hFFFF);
    drive(0, 1, 1, 2'b01, 0, 32'h1004, 0);
    tick();
    expect_st("cnt_wrap", 32'h1004, 0, 0, 0, 16'h0000);

    drive(0, 1, 1, 2'b01, 0, 32'h1007, 0);
    tick();
    expect_st("trap_pre_rst", 32'h1004, 32'h1004, 32'h1007, 1, 16'h0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    expect_st("rst_in_trap", 32'h0, 0, 0, 0, 16'h0);
    drive(0, 0, 0, 2'b00, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    expect_st("after_abort", 32'h0, 0, 0, 0, 16'h0);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending exp 0", q.size());
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_update_unit.md
PC_UPDATE_UNIT -- requirements
Module: pc_update_unit

Interface
REQ-001 Parameter word_size, default 32, datapath width of PC, EPC and targets.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, PC value after reset.
REQ-003 Parameter EXC_VECTOR, default 32'h0000_0180, PC loaded on misaligned-target trap.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 PCWrite  input  1  unconditional PC update request from the control FSM.
REQ-007 PCWriteCond  input  1  conditional PC update request (branch state).
REQ-008 Branch  input  1  branch-taken flag from the branch-compare stage.
REQ-009 PCSource  input  2  next-PC select: 00 alu_result, 01 alu_out, 10 jump, 11 epc.
REQ-010 alu_result  input  word_size  combinational ALU output (PC+4).
REQ-011 alu_out  input  word_size  registered ALU output (branch target).
REQ-012 jump_field  input  26  instruction bits [25:0].
REQ-013 pc  output  word_size  current program counter (registered).
REQ-014 epc  output  word_size  PC of the instruction that caused the last trap (registered).
REQ-015 bad_addr  output  word_size  misaligned target that caused the last trap (registered).
REQ-016 trap  output  1  high for exactly the one cycle the FSM is in TRAP.
REQ-017 branch_cnt  output  16  count of taken conditional branches (registered).

Function
REQ-018 Jump target SHALL be {pc[31:28], jump_field, 2'b00}.
REQ-019 next_pc SHALL be the PCSource-selected value; selection is purely combinational.
REQ-020 Update enable pc_en SHALL be PCWrite | (PCWriteCond & Branch); PCWrite dominates when both requests are asserted.
REQ-021 FSM states SHALL be RUN and TRAP; reset state RUN.
REQ-022 In RUN with pc_en=1 and next_pc[1:0]==00, pc SHALL load next_pc at the next edge; FSM stays RUN.
REQ-023 In RUN with pc_en=1 and next_pc[1:0]!=00: pc SHALL hold, epc SHALL load pc, bad_addr SHALL load next_pc, FSM SHALL go to TRAP.
REQ-024 In RUN with pc_en=0, pc, epc and bad_addr SHALL hold.
REQ-025 In TRAP, pc SHALL load EXC_VECTOR, trap SHALL be 1, FSM SHALL return to RUN; PCWrite, PCWriteCond and Branch are ignored in this cycle.
REQ-026 trap SHALL be a registered-state decode (trap = state==TRAP), never asserted in RUN.
REQ-027 branch_cnt SHALL increment by 1 when PCWriteCond=1, Branch=1, PCWrite=0 and the update is aligned (no trap); it wraps 16'hFFFF -> 16'h0000 without flag.
REQ-028 A misaligned taken branch SHALL NOT increment branch_cnt.
REQ-029 PCSource=11 (return from exception) SHALL load epc through the same alignment check; epc is always aligned, so no trap results.
REQ-030 Latency: one clock from pc_en sample to new pc; two clocks from misaligned request to pc==EXC_VECTOR.

Reset
REQ-031 While rst_n=0, asynchronously: pc=RESET_PC, epc=0, bad_addr=0, branch_cnt=0, state=RUN, trap=0.
REQ-032 Reset asserted in TRAP SHALL abort the trap; after release pc=RESET_PC, not EXC_VECTOR.
REQ-033 First edge after rst_n rises SHALL act on inputs normally (no dead cycle).

Verification
REQ-034 Reset release, PCWrite=1, PCSource=00, alu_result=32'h4 -> pc=32'h4 after one edge, branch_cnt=0.
REQ-035 pc=32'h100, PCWriteCond=1, Branch=1, PCSource=01, alu_out=32'h140 -> pc=32'h140, branch_cnt +1; same with Branch=0 -> pc stays 32'h100, count unchanged.
REQ-036 pc=32'h0040_0010, PCWrite=1, PCSource=10, jump_field=26'h0000_123 -> pc=32'h0000_048C.
REQ-037 pc=32'h200, PCWriteCond=1, Branch=1, PCSource=01, alu_out=32'h202 -> edge1: pc=32'h200, epc=32'h200, bad_addr=32'h202, trap=1; edge2: pc=32'h180, trap=0, branch_cnt unchanged.
REQ-038 branch_cnt preloaded to 16'hFFFF by 65535 taken branches, one more taken branch -> branch_cnt=16'h0000; then rst_n pulsed low during a TRAP cycle -> pc=32'h0, trap=0 immediately.
